// File: rtl/bcd_gray_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_gray_arbiter
//
// Round-robin arbiter in front of a shared BCD-to-Gray converter. In IDLE the
// block picks one active requester, starting the search at ptr and wrapping
// upward. It registers that requester's converted operand and pulses a
// one-cycle ack, then holds the result in OUT until the consumer takes it.
// Operands 10..15 are not BCD digits. They produce gray_out=0 and out_err=1,
// and each one bumps a saturating 8-bit error counter.
//
// Ports
//   clk        : sole clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   en         : grant enable; blocks new grants only
//   req        : per-requester request level [NREQ]
//   bcd_in     : packed operands, requester i at [4i+3:4i]
//   ack        : one-cycle acknowledge to the granted requester [NREQ]
//   out_valid  : result valid (high throughout OUT)
//   out_ready  : consumer accepts the result
//   gray_out   : converted Gray code [4]
//   out_id     : requester that owns the result [IDW]
//   out_err    : operand was not a BCD digit
//   err_count  : saturating count of non-BCD conversions [8]
// -----------------------------------------------------------------------------
module bcd_gray_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] bcd_in,
    output logic [NREQ-1:0]   ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        gray_out,
    output logic [IDW-1:0]    out_id,
    output logic              out_err,
    output logic [7:0]        err_count
);

    typedef enum logic {
        IDLE = 1'b0,
        OUT  = 1'b1
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;
    logic           grant;
    logic           take;
    logic [3:0]     operand;
    logic           operand_bad;
    logic [IDW-1:0] ptr_next;
    int             idx;

    // Digits 0..9 map to the plain binary-reflected Gray code. Non-digits
    // map to zero.
    function automatic logic [3:0] bcd_to_gray(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : (d ^ (d >> 1));
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Round-robin search: take the first active request at ptr, ptr+1, ...,
    // wrapping modulo NREQ. This works when NREQ is not a power of two.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign operand     = bcd_in[{win, 2'b00} +: 4];
    assign operand_bad = (operand > 4'd9);
    assign ptr_next    = (out_id == IDW'(NREQ - 1)) ? '0 : out_id + IDW'(1);

    // Next-state logic. OUT never arbitrates, so req and en are ignored
    // there. Because out_valid is high throughout OUT, the handshake is just
    // out_ready seen in OUT.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    grant      = 1'b1;
                    next_state = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    take       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Results, ack and out_valid are all registered, so they appear together
    // in the first OUT cycle. A reset taken in OUT drops the pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            ack       <= '0;
            out_valid <= 1'b0;
            gray_out  <= 4'd0;
            out_id    <= '0;
            out_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            ack <= '0;
            if (grant) begin
                ack[win]  <= 1'b1;
                out_valid <= 1'b1;
                gray_out  <= bcd_to_gray(operand);
                out_id    <= win;
                out_err   <= operand_bad;
                if (operand_bad) err_count <= sat_inc(err_count);
            end else if (take) begin
                out_valid <= 1'b0;
                ptr       <= ptr_next;
            end
        end
    end

endmodule
